multi_ball_hit_controller: RTL and testbench
============================================

# multi_ball_hit_controller

Frame-based collision resolver for NUM_BALLS balls. It accumulates pixel-level overlaps (ball/border, ball/ball, ball/hole) during each video frame. At frame start it resolves the captured events ball by ball and publishes corrected velocities, per-ball collision pulses and hole-hit reports. It sits between the object drawers and the per-ball movement blocks, and adds ball-to-ball response, N-ball scaling and explicit priority.

## Interface
- NUM_BALLS, 2, number of balls (2..16)
- NUM_HOLES, 6, number of hole draw requests (1..8)
- POS_W, 11, unsigned position width
- VEL_W, 11, signed velocity width
- LEFT_OFFSET / RIGHT_OFFSET / TOP_OFFSET / DOWN_OFFSET, 0 / 639 / 0 / 479, table extents used for border side decisions

- clk  in  1  system clock; one clock only
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at the frame boundary
- ballDR  in  NUM_BALLS  per-ball draw request for the current pixel
- bordersDR  in  1  border draw request
- holeDR  in  NUM_HOLES  per-hole draw request
- ballPosX, ballPosY  in  NUM_BALLS×POS_W  top-left position per ball
- ballVelX, ballVelY  in  NUM_BALLS×VEL_W  current signed velocity per ball
- ballVelXOut, ballVelYOut  out  NUM_BALLS×VEL_W  resolved velocity, held between publishes
- collisionOccurred  out  NUM_BALLS  one-cycle pulse per ball with a border or ball event
- holeHit  out  NUM_BALLS  one-cycle pulse per ball that entered a hole
- holeNum  out  NUM_BALLS×3  lowest-index hole overlapped; held with holeHit
- busy  out  1  high while RESOLVE runs
- overrun  out  1  one-cycle pulse when startOfFrame arrives while busy

## Operation
- Accumulators are sticky flags, set on any cycle in which the overlap holds:
  - borderHit[i] = ballDR[i] & bordersDR
  - pairHit[i][j] (i<j) = ballDR[i] & ballDR[j]
  - holeMask[i][k] = ballDR[i] & holeDR[k]
- On startOfFrame, in the same cycle:
  - all accumulators, ballPos and ballVel are copied into a snapshot
  - the accumulators are cleared
  - the flags set in that cycle go to the new frame
- FSM states:
  - IDLE → ACCUM after reset.
  - ACCUM → RESOLVE on startOfFrame.
  - RESOLVE visits ball index 0..NUM_BALLS-1, one per cycle, then goes to PUBLISH.
  - PUBLISH (1 cycle) → ACCUM.
- Per-ball priority is hole > ball-ball > border > none.
  - Hole: velocity out = 0,0; holeHit=1; holeNum = lowest k in holeMask[i].
  - Ball-ball: partner p = lowest-index ball with pairHit set; ball i takes the snapshot velocity of p (swap). No arithmetic.
  - Border:
    - If posX < (LEFT_OFFSET+RIGHT_OFFSET)/2 and velX<0, or posX ≥ midpoint and velX>0, then velX = -velX.
    - The same rule applies to Y with TOP_OFFSET/DOWN_OFFSET.
    - Otherwise the velocity is unchanged.
  - None: velocity out = snapshot velocity.
- Negation saturates: -(-2^(VEL_W-1)) = 2^(VEL_W-1)-1.
- A partner that is itself in a hole still supplies its snapshot velocity.
- collisionOccurred[i] = ball-ball or border event, and no hole event.
- Results are written to shadow registers during RESOLVE. Outputs update together in PUBLISH.
- If startOfFrame arrives during RESOLVE or PUBLISH:
  - the snapshot is not overwritten
  - overrun pulses
  - the accumulators still clear
  - the pending resolve completes normally

## Timing
- startOfFrame at cycle T → busy high T+1..T+NUM_BALLS → outputs and pulses valid at T+NUM_BALLS+1.
- Latency is NUM_BALLS+1 cycles and is fixed.
- Reset values:
  - all velocity outputs 0
  - collisionOccurred, holeHit, holeNum, busy, overrun all 0
  - FSM in IDLE; accumulators and snapshot cleared
- IDLE → ACCUM occurs on the first clock after reset deasserts.
- Reset asserted mid-RESOLVE aborts immediately. No publish occurs and outputs return to reset values.
- startOfFrame in IDLE is ignored.

## Structure
- Package hit_pkg:
  - hit_state_t enum (IDLE, ACCUM, RESOLVE, PUBLISH)
  - hit_event_t enum (EV_NONE, EV_BORDER, EV_BALL, EV_HOLE)
  - a saturating-negate function
  - a lowest-set-bit function
- Sub-module hit_event_accum: the sticky flag matrix plus the snapshot registers, cleared on startOfFrame.
- The top level holds the FSM, the per-index resolve datapath and the output registers.

## Test plan
- Ball0 at (100,200), vel (-5,3), borderHit set → after startOfFrame at T, vel0Out=(5,3) and collisionOccurred[0]=1 at exactly T+3.
- Ball0 vel (4,0) and ball1 vel (-2,1) overlap → outputs (-2,1) and (4,0); both collisionOccurred pulse.
- Ball1 overlaps hole 3 and border in the same frame → vel1Out=(0,0), holeHit[1]=1, holeNum[1]=3, collisionOccurred[1]=0.
- velX=-1024 with a left-half border hit → velXOut=1023.
- startOfFrame at T and T+1 → overrun=1 at T+1; results for frame T are still published at T+3.
- Reset asserted at T+1 mid-resolve → no pulses; all outputs 0 at the next edge.

Source files
------------

// File: rtl/hit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hit_pkg
// Brief    : Shared types and helpers for the multi-ball hit controller.
// Revision : 1.0 - initial release
// ============================================================================
package hit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    PUBLISH = 2'd3
  } hit_state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_BORDER = 2'd1,
    EV_BALL   = 2'd2,
    EV_HOLE   = 2'd3
  } hit_event_t;

  localparam int MAX_BALLS  = 16;
  localparam int HOLE_IDX_W = 3;

  // Two's complement negate of a w-bit value; the most negative code maps to the most positive.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (w - 1));
    if (v == most_neg) sat_neg = -most_neg - 32'sd1;
    else               sat_neg = -v;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [MAX_BALLS-1:0] v);
    lowest_set = 4'd0;
    for (int i = MAX_BALLS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_ball_hit_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_ball_hit_controller_if
// Brief    : Draw-request inputs and resolved-velocity outputs of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_ball_hit_controller_if #(
  parameter int NUM_BALLS = 2,
  parameter int NUM_HOLES = 6,
  parameter int POS_W     = 11,
  parameter int VEL_W     = 11
);
  import hit_pkg::*;

  logic                                 startOfFrame;
  logic [NUM_BALLS-1:0]                 ballDR;
  logic                                 bordersDR;
  logic [NUM_HOLES-1:0]                 holeDR;
  logic [NUM_BALLS-1:0][POS_W-1:0]      ballPosX;
  logic [NUM_BALLS-1:0][POS_W-1:0]      ballPosY;
  logic [NUM_BALLS-1:0][VEL_W-1:0]      ballVelX;
  logic [NUM_BALLS-1:0][VEL_W-1:0]      ballVelY;
  logic [NUM_BALLS-1:0][VEL_W-1:0]      ballVelXOut;
  logic [NUM_BALLS-1:0][VEL_W-1:0]      ballVelYOut;
  logic [NUM_BALLS-1:0]                 collisionOccurred;
  logic [NUM_BALLS-1:0]                 holeHit;
  logic [NUM_BALLS-1:0][HOLE_IDX_W-1:0] holeNum;
  logic                                 busy;
  logic                                 overrun;

  modport master (
    output startOfFrame, ballDR, bordersDR, holeDR,
    output ballPosX, ballPosY, ballVelX, ballVelY,
    input  ballVelXOut, ballVelYOut, collisionOccurred, holeHit, holeNum, busy, overrun
  );

  modport slave (
    input  startOfFrame, ballDR, bordersDR, holeDR,
    input  ballPosX, ballPosY, ballVelX, ballVelY,
    output ballVelXOut, ballVelYOut, collisionOccurred, holeHit, holeNum, busy, overrun
  );

endinterface
`default_nettype wire

// File: rtl/hit_event_accum.sv
`default_nettype none
// ============================================================================
// Module   : hit_event_accum
// Brief    : Sticky per-frame overlap flags plus the frame-boundary snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module hit_event_accum #(
  parameter int NUM_BALLS = 2,
  parameter int NUM_HOLES = 6,
  parameter int POS_W     = 11,
  parameter int VEL_W     = 11
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 capture,
  input  logic [NUM_BALLS-1:0]                 ball_dr,
  input  logic                                 border_dr,
  input  logic [NUM_HOLES-1:0]                 hole_dr,
  input  logic [NUM_BALLS-1:0][POS_W-1:0]      pos_x,
  input  logic [NUM_BALLS-1:0][POS_W-1:0]      pos_y,
  input  logic [NUM_BALLS-1:0][VEL_W-1:0]      vel_x,
  input  logic [NUM_BALLS-1:0][VEL_W-1:0]      vel_y,
  output logic [NUM_BALLS-1:0]                 snap_border,
  output logic [NUM_BALLS-1:0][NUM_BALLS-1:0]  snap_pair,
  output logic [NUM_BALLS-1:0][NUM_HOLES-1:0]  snap_hole,
  output logic [NUM_BALLS-1:0][POS_W-1:0]      snap_pos_x,
  output logic [NUM_BALLS-1:0][POS_W-1:0]      snap_pos_y,
  output logic [NUM_BALLS-1:0][VEL_W-1:0]      snap_vel_x,
  output logic [NUM_BALLS-1:0][VEL_W-1:0]      snap_vel_y
);
  import hit_pkg::*;

  logic [NUM_BALLS-1:0]                cur_border, border_acc;
  logic [NUM_BALLS-1:0][NUM_BALLS-1:0] cur_pair,   pair_acc;
  logic [NUM_BALLS-1:0][NUM_HOLES-1:0] cur_hole,   hole_acc;

  // Pair flags are kept symmetric so each ball reads its own row for partners.
  generate
    for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
      assign cur_border[i] = ball_dr[i] & border_dr;
      assign cur_hole[i]   = {NUM_HOLES{ball_dr[i]}} & hole_dr;
      for (genvar j = 0; j < NUM_BALLS; j++) begin : g_pair
        if (i == j) begin : g_diag
          assign cur_pair[i][j] = 1'b0;
        end else begin : g_off
          assign cur_pair[i][j] = ball_dr[i] & ball_dr[j];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      border_acc  <= '0;
      pair_acc    <= '0;
      hole_acc    <= '0;
      snap_border <= '0;
      snap_pair   <= '0;
      snap_hole   <= '0;
      snap_pos_x  <= '0;
      snap_pos_y  <= '0;
      snap_vel_x  <= '0;
      snap_vel_y  <= '0;
    end else begin
      // Overlaps seen on the clearing cycle belong to the frame that is starting.
      border_acc <= (clear ? '0 : border_acc) | cur_border;
      pair_acc   <= (clear ? '0 : pair_acc)   | cur_pair;
      hole_acc   <= (clear ? '0 : hole_acc)   | cur_hole;
      if (capture) begin
        snap_border <= border_acc;
        snap_pair   <= pair_acc;
        snap_hole   <= hole_acc;
        snap_pos_x  <= pos_x;
        snap_pos_y  <= pos_y;
        snap_vel_x  <= vel_x;
        snap_vel_y  <= vel_y;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_ball_hit_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_ball_hit_controller
// Brief    : Frame FSM, per-ball event resolution and published output registers.
// Revision : 1.0 - initial release
// ============================================================================
module multi_ball_hit_controller #(
  parameter int NUM_BALLS    = 2,
  parameter int NUM_HOLES    = 6,
  parameter int POS_W        = 11,
  parameter int VEL_W        = 11,
  parameter int LEFT_OFFSET  = 0,
  parameter int RIGHT_OFFSET = 639,
  parameter int TOP_OFFSET   = 0,
  parameter int DOWN_OFFSET  = 479
) (
  input  logic                         clk,
  input  logic                         reset,
  multi_ball_hit_controller_if.slave   bus
);
  import hit_pkg::*;

  localparam int               IDX_W    = $clog2(NUM_BALLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);
  localparam logic [POS_W-1:0] MID_X    = POS_W'((LEFT_OFFSET + RIGHT_OFFSET) / 2);
  localparam logic [POS_W-1:0] MID_Y    = POS_W'((TOP_OFFSET + DOWN_OFFSET) / 2);

  hit_state_t       state, state_next;
  logic [IDX_W-1:0] idx;
  logic             busy_now, overrun_now, capture, clear;

  logic [NUM_BALLS-1:0]                snap_border;
  logic [NUM_BALLS-1:0][NUM_BALLS-1:0] snap_pair;
  logic [NUM_BALLS-1:0][NUM_HOLES-1:0] snap_hole;
  logic [NUM_BALLS-1:0][POS_W-1:0]     snap_pos_x, snap_pos_y;
  logic [NUM_BALLS-1:0][VEL_W-1:0]     snap_vel_x, snap_vel_y;

  logic [NUM_BALLS-1:0]                 pair_row;
  logic [NUM_HOLES-1:0]                 hole_row;
  logic [IDX_W-1:0]                     partner;
  logic [POS_W-1:0]                     cur_px, cur_py;
  logic [VEL_W-1:0]                     cur_vx, cur_vy, res_vx, res_vy;
  logic                                 res_coll, res_hit;
  logic [HOLE_IDX_W-1:0]                res_hnum;
  hit_event_t                           ev;

  logic [NUM_BALLS-1:0][VEL_W-1:0]      shadow_vx, shadow_vy, merged_vx, merged_vy;
  logic [NUM_BALLS-1:0]                 shadow_coll, shadow_hit, merged_coll, merged_hit;
  logic [NUM_BALLS-1:0][HOLE_IDX_W-1:0] shadow_hnum, merged_hnum;

  logic [NUM_BALLS-1:0][VEL_W-1:0]      vel_x_out, vel_y_out;
  logic [NUM_BALLS-1:0]                 coll_out, hit_out;
  logic [NUM_BALLS-1:0][HOLE_IDX_W-1:0] hnum_out;

  // A frame boundary outside ACCUM still clears the flags but keeps the pending snapshot.
  assign capture = bus.startOfFrame && (state == ACCUM);
  assign clear   = bus.startOfFrame && (state != IDLE);

  hit_event_accum #(
    .NUM_BALLS (NUM_BALLS),
    .NUM_HOLES (NUM_HOLES),
    .POS_W     (POS_W),
    .VEL_W     (VEL_W)
  ) u_accum (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .capture     (capture),
    .ball_dr     (bus.ballDR),
    .border_dr   (bus.bordersDR),
    .hole_dr     (bus.holeDR),
    .pos_x       (bus.ballPosX),
    .pos_y       (bus.ballPosY),
    .vel_x       (bus.ballVelX),
    .vel_y       (bus.ballVelY),
    .snap_border (snap_border),
    .snap_pair   (snap_pair),
    .snap_hole   (snap_hole),
    .snap_pos_x  (snap_pos_x),
    .snap_pos_y  (snap_pos_y),
    .snap_vel_x  (snap_vel_x),
    .snap_vel_y  (snap_vel_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy_now    = 1'b0;
    overrun_now = 1'b0;
    case (state)
      IDLE:    state_next = ACCUM;
      ACCUM:   if (bus.startOfFrame) state_next = RESOLVE;
      RESOLVE: begin
        busy_now    = 1'b1;
        overrun_now = bus.startOfFrame;
        if (idx == LAST_IDX) state_next = PUBLISH;
      end
      PUBLISH: begin
        overrun_now = bus.startOfFrame;
        state_next  = ACCUM;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      idx <= '0;
    else if (state == RESOLVE && idx != LAST_IDX)   idx <= idx + 1'b1;
    else                                            idx <= '0;
  end

  // Resolution of the ball currently addressed by idx, priority hole > ball > border.
  always_comb begin
    pair_row = snap_pair[idx];
    hole_row = snap_hole[idx];
    cur_px   = snap_pos_x[idx];
    cur_py   = snap_pos_y[idx];
    cur_vx   = snap_vel_x[idx];
    cur_vy   = snap_vel_y[idx];
    partner  = IDX_W'(lowest_set(MAX_BALLS'(pair_row)));

    ev = EV_NONE;
    if (|hole_row)             ev = EV_HOLE;
    else if (|pair_row)        ev = EV_BALL;
    else if (snap_border[idx]) ev = EV_BORDER;

    res_vx   = cur_vx;
    res_vy   = cur_vy;
    res_coll = 1'b0;
    res_hit  = 1'b0;
    res_hnum = '0;
    case (ev)
      EV_HOLE: begin
        res_vx   = '0;
        res_vy   = '0;
        res_hit  = 1'b1;
        res_hnum = HOLE_IDX_W'(lowest_set(MAX_BALLS'(hole_row)));
      end
      EV_BALL: begin
        res_vx   = snap_vel_x[partner];
        res_vy   = snap_vel_y[partner];
        res_coll = 1'b1;
      end
      EV_BORDER: begin
        res_coll = 1'b1;
        // Reflect only when moving toward the nearer wall on that axis.
        if ((cur_px < MID_X && cur_vx[VEL_W-1]) ||
            (cur_px >= MID_X && !cur_vx[VEL_W-1] && |cur_vx))
          res_vx = VEL_W'(sat_neg(32'($signed(cur_vx)), VEL_W));
        if ((cur_py < MID_Y && cur_vy[VEL_W-1]) ||
            (cur_py >= MID_Y && !cur_vy[VEL_W-1] && |cur_vy))
          res_vy = VEL_W'(sat_neg(32'($signed(cur_vy)), VEL_W));
      end
      default: ;
    endcase
  end

  always_comb begin
    merged_vx        = shadow_vx;
    merged_vy        = shadow_vy;
    merged_coll      = shadow_coll;
    merged_hit       = shadow_hit;
    merged_hnum      = shadow_hnum;
    merged_vx[idx]   = res_vx;
    merged_vy[idx]   = res_vy;
    merged_coll[idx] = res_coll;
    merged_hit[idx]  = res_hit;
    merged_hnum[idx] = res_hnum;
  end

  // The final ball is folded in directly so every output changes on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_vx   <= '0;
      shadow_vy   <= '0;
      shadow_coll <= '0;
      shadow_hit  <= '0;
      shadow_hnum <= '0;
      vel_x_out   <= '0;
      vel_y_out   <= '0;
      coll_out    <= '0;
      hit_out     <= '0;
      hnum_out    <= '0;
    end else begin
      coll_out <= '0;
      hit_out  <= '0;
      if (state == RESOLVE) begin
        shadow_vx[idx]   <= res_vx;
        shadow_vy[idx]   <= res_vy;
        shadow_coll[idx] <= res_coll;
        shadow_hit[idx]  <= res_hit;
        shadow_hnum[idx] <= res_hnum;
        if (idx == LAST_IDX) begin
          vel_x_out <= merged_vx;
          vel_y_out <= merged_vy;
          coll_out  <= merged_coll;
          hit_out   <= merged_hit;
          hnum_out  <= merged_hnum;
        end
      end
    end
  end

  assign bus.ballVelXOut       = vel_x_out;
  assign bus.ballVelYOut       = vel_y_out;
  assign bus.collisionOccurred = coll_out;
  assign bus.holeHit           = hit_out;
  assign bus.holeNum           = hnum_out;
  assign bus.busy              = busy_now;
  assign bus.overrun           = overrun_now;

endmodule
`default_nettype wire

// File: tb/tb_multi_ball_hit_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_ball_hit_controller
// Brief    : Directed and randomized frames checked against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_ball_hit_controller;

  localparam int NB    = 2;
  localparam int NH    = 6;
  localparam int PW    = 11;
  localparam int VW    = 11;
  localparam int MID_X = (0 + 639) / 2;
  localparam int MID_Y = (0 + 479) / 2;
  localparam int VMIN  = -1024;
  localparam int VMAX  = 1023;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_ball_hit_controller_if #(.NUM_BALLS(NB), .NUM_HOLES(NH), .POS_W(PW), .VEL_W(VW)) bus ();

  multi_ball_hit_controller #(
    .NUM_BALLS(NB), .NUM_HOLES(NH), .POS_W(PW), .VEL_W(VW),
    .LEFT_OFFSET(0), .RIGHT_OFFSET(639), .TOP_OFFSET(0), .DOWN_OFFSET(479)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int prob     = 4;

  int pos_x[NB], pos_y[NB], vel_x[NB], vel_y[NB];
  bit dr_ball[NB], dr_hole[NH], dr_border, sof;

  bit acc_border[NB], acc_pair[NB][NB], acc_hole[NB][NH];
  bit sn_border[NB],  sn_pair[NB][NB],  sn_hole[NB][NH];
  int sn_px[NB], sn_py[NB], sn_vx[NB], sn_vy[NB];

  int exp_vx[NB], exp_vy[NB], exp_hnum[NB];
  bit exp_coll[NB], exp_hit[NB];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int reflect(input int pos, input int v, input int mid);
    if ((pos < mid && v < 0) || (pos >= mid && v > 0)) return (v == VMIN) ? VMAX : -v;
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) begin
      acc_border[i] = 0; sn_border[i] = 0;
      sn_px[i] = 0; sn_py[i] = 0; sn_vx[i] = 0; sn_vy[i] = 0;
      exp_vx[i] = 0; exp_vy[i] = 0;
      for (int j = 0; j < NB; j++) begin acc_pair[i][j] = 0; sn_pair[i][j] = 0; end
      for (int k = 0; k < NH; k++) begin acc_hole[i][k] = 0; sn_hole[i][k] = 0; end
    end
  endfunction

  // Reference behaviour at each clock edge: snapshot, clear, then record this cycle's overlaps.
  function automatic void model_edge(input bit capture);
    if (capture) begin
      sn_border = acc_border; sn_pair = acc_pair; sn_hole = acc_hole;
      sn_px = pos_x; sn_py = pos_y; sn_vx = vel_x; sn_vy = vel_y;
    end
    if (sof) begin
      for (int i = 0; i < NB; i++) begin
        acc_border[i] = 0;
        for (int j = 0; j < NB; j++) acc_pair[i][j] = 0;
        for (int k = 0; k < NH; k++) acc_hole[i][k] = 0;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (dr_ball[i] && dr_border) acc_border[i] = 1;
      for (int j = 0; j < NB; j++) if (j != i && dr_ball[i] && dr_ball[j]) acc_pair[i][j] = 1;
      for (int k = 0; k < NH; k++) if (dr_ball[i] && dr_hole[k]) acc_hole[i][k] = 1;
    end
  endfunction

  function automatic void compute_expected();
    for (int i = 0; i < NB; i++) begin
      int hk = -1;
      int p  = -1;
      for (int k = NH - 1; k >= 0; k--) if (sn_hole[i][k]) hk = k;
      for (int j = NB - 1; j >= 0; j--) if (j != i && sn_pair[i][j]) p = j;
      exp_coll[i] = 0; exp_hit[i] = 0; exp_hnum[i] = 0;
      if (hk >= 0) begin
        exp_vx[i] = 0; exp_vy[i] = 0; exp_hit[i] = 1; exp_hnum[i] = hk;
      end else if (p >= 0) begin
        exp_vx[i] = sn_vx[p]; exp_vy[i] = sn_vy[p]; exp_coll[i] = 1;
      end else if (sn_border[i]) begin
        exp_vx[i] = reflect(sn_px[i], sn_vx[i], MID_X);
        exp_vy[i] = reflect(sn_py[i], sn_vy[i], MID_Y);
        exp_coll[i] = 1;
      end else begin
        exp_vx[i] = sn_vx[i]; exp_vy[i] = sn_vy[i];
      end
    end
  endfunction

  task automatic apply();
    bus.startOfFrame = sof;
    bus.bordersDR    = dr_border;
    for (int i = 0; i < NB; i++) begin
      bus.ballDR[i]   = dr_ball[i];
      bus.ballPosX[i] = PW'(pos_x[i]);
      bus.ballPosY[i] = PW'(pos_y[i]);
      bus.ballVelX[i] = VW'(vel_x[i]);
      bus.ballVelY[i] = VW'(vel_y[i]);
    end
    for (int k = 0; k < NH; k++) bus.holeDR[k] = dr_hole[k];
  endtask

  task automatic quiet();
    dr_border = 0;
    for (int i = 0; i < NB; i++) dr_ball[i] = 0;
    for (int k = 0; k < NH; k++) dr_hole[k] = 0;
  endtask

  function automatic int rand_vel();
    case ($urandom_range(0, 7))
      0:       return VMIN;
      1:       return VMAX;
      default: return int'($urandom_range(0, 2047)) - 1024;
    endcase
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < NB; i++) begin
      dr_ball[i] = ($urandom_range(0, prob - 1) == 0);
      pos_x[i]   = int'($urandom_range(0, 639));
      pos_y[i]   = int'($urandom_range(0, 479));
      vel_x[i]   = rand_vel();
      vel_y[i]   = rand_vel();
    end
    dr_border = ($urandom_range(0, 1) == 0);
    for (int k = 0; k < NH; k++) dr_hole[k] = ($urandom_range(0, 15) == 0);
  endtask

  task automatic tick(input bit capture, input bit watch_overrun);
    apply();
    #1;
    if (watch_overrun) check("overrun", int'(bus.overrun), int'(sof));
    @(posedge clk);
    model_edge(capture);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < NB; i++) begin
      check({tag, "_vx"}, int'($signed(bus.ballVelXOut[i])), 0);
      check({tag, "_vy"}, int'($signed(bus.ballVelYOut[i])), 0);
    end
    check({tag, "_pulses"}, int'({bus.collisionOccurred, bus.holeHit, bus.busy, bus.overrun}), 0);
  endtask

  // sof at T, busy over T+1..T+NB, results and pulses at T+NB+1, pulses gone at T+NB+2.
  task automatic resolve_frame(input bit randomize, input bit ovr);
    if (randomize) rand_inputs(); else quiet();
    sof = 1;
    tick(1'b1, 1'b0);
    compute_expected();
    for (int c = 1; c <= NB; c++) begin
      check("busy", int'(bus.busy), 1);
      check("early_pulse", int'({bus.collisionOccurred, bus.holeHit}), 0);
      if (randomize) rand_inputs(); else quiet();
      sof = ovr && (c == 1);
      tick(1'b0, 1'b1);
    end
    sof = 0;
    check("busy_publish", int'(bus.busy), 0);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("vx[%0d]", i), int'($signed(bus.ballVelXOut[i])), exp_vx[i]);
      check($sformatf("vy[%0d]", i), int'($signed(bus.ballVelYOut[i])), exp_vy[i]);
      check($sformatf("coll[%0d]", i), int'(bus.collisionOccurred[i]), int'(exp_coll[i]));
      check($sformatf("hit[%0d]", i), int'(bus.holeHit[i]), int'(exp_hit[i]));
      if (exp_hit[i]) check($sformatf("hnum[%0d]", i), int'(bus.holeNum[i]), exp_hnum[i]);
    end
    if (randomize) rand_inputs(); else quiet();
    tick(1'b0, 1'b1);
    check("pulse_drop", int'({bus.collisionOccurred, bus.holeHit}), 0);
    for (int i = 0; i < NB; i++)
      check($sformatf("vx_hold[%0d]", i), int'($signed(bus.ballVelXOut[i])), exp_vx[i]);
  endtask

  task automatic set_ball(input int i, input int px, input int py, input int vx, input int vy);
    pos_x[i] = px; pos_y[i] = py; vel_x[i] = vx; vel_y[i] = vy;
  endtask

  initial begin
    reset = 1; sof = 0;
    quiet();
    for (int i = 0; i < NB; i++) set_ball(i, 0, 0, 0, 0);
    model_clear();
    apply();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Border reflection toward the left wall only.
    set_ball(0, 100, 200, -5, 3);
    set_ball(1, 400, 300, 7, -2);
    quiet(); dr_ball[0] = 1; dr_border = 1; tick(1'b0, 1'b0);
    quiet(); tick(1'b0, 1'b0);
    resolve_frame(1'b0, 1'b0);
    check("tp_border_vx0", int'($signed(bus.ballVelXOut[0])), 5);
    check("tp_border_vy0", int'($signed(bus.ballVelYOut[0])), 3);

    // Ball-ball swap.
    set_ball(0, 300, 200, 4, 0);
    set_ball(1, 310, 205, -2, 1);
    quiet(); dr_ball[0] = 1; dr_ball[1] = 1; tick(1'b0, 1'b0);
    quiet(); tick(1'b0, 1'b0);
    resolve_frame(1'b0, 1'b0);
    check("tp_swap_vx0", int'($signed(bus.ballVelXOut[0])), -2);
    check("tp_swap_vy0", int'($signed(bus.ballVelYOut[0])), 1);
    check("tp_swap_vx1", int'($signed(bus.ballVelXOut[1])), 4);
    check("tp_swap_vy1", int'($signed(bus.ballVelYOut[1])), 0);

    // Hole beats border; lowest hole index wins.
    set_ball(1, 600, 50, 9, -9);
    quiet(); dr_ball[1] = 1; dr_border = 1; dr_hole[5] = 1; tick(1'b0, 1'b0);
    quiet(); dr_ball[1] = 1; dr_hole[3] = 1; tick(1'b0, 1'b0);
    quiet(); tick(1'b0, 1'b0);
    resolve_frame(1'b0, 1'b0);
    check("tp_hole_num1", int'(bus.holeNum[1]), 3);
    check("tp_hole_vx1", int'($signed(bus.ballVelXOut[1])), 0);

    // Saturating negate of the most negative velocity.
    set_ball(0, 100, 400, VMIN, VMAX);
    quiet(); dr_ball[0] = 1; dr_border = 1; tick(1'b0, 1'b0);
    quiet(); tick(1'b0, 1'b0);
    resolve_frame(1'b0, 1'b0);
    check("tp_sat_vx0", int'($signed(bus.ballVelXOut[0])), VMAX);
    check("tp_sat_vy0", int'($signed(bus.ballVelYOut[0])), -VMAX);

    // Back-to-back frame boundary while busy.
    set_ball(0, 630, 470, 6, 8);
    quiet(); dr_ball[0] = 1; dr_border = 1; tick(1'b0, 1'b0);
    quiet(); tick(1'b0, 1'b0);
    resolve_frame(1'b0, 1'b1);
    check("tp_ovr_vx0", int'($signed(bus.ballVelXOut[0])), -6);

    // Reset in the middle of a resolve: nothing is published.
    quiet(); dr_ball[0] = 1; dr_ball[1] = 1; tick(1'b0, 1'b0);
    quiet(); sof = 1; tick(1'b1, 1'b0);
    sof = 0; apply();
    check("mid_busy", int'(bus.busy), 1);
    reset = 1;
    #1;
    check_outputs_zero("rst_async");
    @(posedge clk);
    #1;
    check_outputs_zero("rst_edge");
    reset = 0;
    model_clear();
    for (int c = 0; c < NB + 2; c++) begin
      tick(1'b0, 1'b0);
      check_outputs_zero("rst_after");
    end

    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 2))
        0:       prob = 2;
        1:       prob = 3;
        default: prob = 6;
      endcase
      repeat ($urandom_range(2, 12)) begin
        rand_inputs(); sof = 0; tick(1'b0, 1'b0);
      end
      resolve_frame(1'b1, (f % 7) == 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
